// File: rtl/bus_initiator_pkg.sv
// bus_initiator_pkg: shared types and constants for the single-outstanding bus initiator.
//   bus_init_state_t         - initiator FSM state encoding
//   BUS_INIT_DEFAULT_TIMEOUT - default cycle bound for the grant and rvalid waits
//   BUS_INIT_ERR_RDATA       - read data returned with writes and error responses
package bus_initiator_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitRsp,
        StResp
    } bus_init_state_t;

    localparam int unsigned BUS_INIT_DEFAULT_TIMEOUT = 16;
    localparam logic [31:0] BUS_INIT_ERR_RDATA       = 32'h0;

endpackage

// File: rtl/bus_initiator_if.sv
// bus_initiator_if: host command/response port plus req/gnt/rvalid peripheral bus.
//   command : cmd_valid, cmd_ready, cmd_we, cmd_addr, cmd_wdata, cmd_be
//   response: rsp_valid, rsp_ready, rsp_rdata, rsp_err
//   bus     : req, addr, wdata, we, be, gnt, rvalid, rdata
// modport master is the initiator's view; modport slave is the host/peripheral side.
interface bus_initiator_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_be, rsp_ready, gnt, rvalid, rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, req, addr, wdata, we, be
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_be, rsp_ready, gnt, rvalid, rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, req, addr, wdata, we, be
    );

endinterface

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter: saturating wait-cycle counter shared by the grant and rvalid waits.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - restart the count at zero (has priority over enable)
//   enable     - count one more elapsed wait cycle
//   expired    - the current wait cycle is the TIMEOUT_CYCLES-th one
module bus_timeout_counter
    import bus_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = BUS_INIT_DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] MAX   = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != MAX)) begin
            count_d = count_q + CW'(1);
        end
    end

    // count_q holds the cycles already elapsed, so the final allowed cycle sees LAST.
    assign expired = (count_q >= LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding req/gnt/rvalid bus master with bounded waits.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - bus_initiator_if.master: host command/response port and peripheral bus
// A command is latched in IDLE, requested until granted, then the response is awaited.
// Either wait exceeding TIMEOUT_CYCLES produces an error response with zero read data.
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = BUS_INIT_DEFAULT_TIMEOUT
) (
    input logic             clk,
    input logic             rst_n,
    bus_initiator_if.master bus
);

    bus_init_state_t state_q, state_d;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic cmd_fire;
    logic cnt_clear;
    logic cnt_en;
    logic expired;

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cmd_fire  = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_clear = 1'b1;
                if (bus.cmd_valid) begin
                    cmd_fire = 1'b1;
                    state_d  = StReq;
                end
            end
            StReq: begin
                // A grant in the final allowed cycle still wins over the timeout.
                if (bus.gnt) begin
                    cnt_clear = 1'b1;
                    state_d   = StWaitRsp;
                end else begin
                    cnt_en = 1'b1;
                    if (expired) begin
                        rdata_d = BUS_INIT_ERR_RDATA;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StWaitRsp: begin
                if (bus.rvalid) begin
                    rdata_d = we_q ? BUS_INIT_ERR_RDATA : bus.rdata;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else begin
                    cnt_en = 1'b1;
                    if (expired) begin
                        rdata_d = BUS_INIT_ERR_RDATA;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (cmd_fire) begin
                we_q    <= bus.cmd_we;
                addr_q  <= bus.cmd_addr;
                wdata_q <= bus.cmd_wdata;
                be_q    <= bus.cmd_be;
            end
        end
    end

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .expired(expired)
    );

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.req       = (state_q == StReq);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.we        = we_q;
    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.be        = be_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule
